// File: rtl/snake_pkg.sv
// Shared types, LFSR constants and helpers for the snake game sequencer.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Opposite directions share bit 1 and differ only in bit 0.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/snake_tick.sv
// Game tick divider: one-cycle tick every DIV enabled cycles; count clears when disabled.
module snake_tick #(
  parameter int DIV = 5_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg <= '0;
    end else if (!en || (cnt_reg == CNT_MAX)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = en && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: FSM, head stepping, food placement and score.
// Define SNAKE_WRAP_EN to make the playfield edges wrap instead of ending the game.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int TICK_DIV = 5_000_000,
  parameter int START_X  = 16,
  parameter int START_Y  = 12,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [1:0]         direction,
  input  logic               run,
  input  logic               restart,
  output logic [XW-1:0]      head_x,
  output logic [YW-1:0]      head_y,
  output logic [XW-1:0]      food_x,
  output logic [YW-1:0]      food_y,
  output logic [SCORE_W-1:0] score,
  output logic               step,
  output logic [1:0]         state,
  output logic               game_over
);

  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);
  localparam logic [XW-1:0] X_FOOD0 = XW'((START_X + 4) % GRID_W);
  localparam logic [XW:0]   GRID_W_EXT = (XW + 1)'(GRID_W);
  localparam logic [YW:0]   GRID_H_EXT = (YW + 1)'(GRID_H);

  state_t               state_reg, state_next;
  dir_t                 cur_dir_reg, pend_dir_reg, dir_in;
  logic [XW-1:0]        head_x_reg, head_x_next, food_x_reg, food_x_next;
  logic [YW-1:0]        head_y_reg, head_y_next, food_y_reg, food_y_next;
  logic [SCORE_W-1:0]   score_reg;
  logic                 step_reg;
  logic [15:0]          lfsr_reg;
  logic                 tick_en, tick, collide, eat;
  logic [XW-1:0]        fx_raw;
  logic [YW-1:0]        fy_raw;

  assign dir_in  = dir_t'(direction);
  // Gating with run drops a tick that coincides with run falling.
  assign tick_en = (state_reg == RUN) && run && !restart;

  snake_tick #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .clr  (clr),
    .en   (tick_en),
    .tick (tick)
  );

  // Candidate head for the pending direction, with edge handling.
  always_comb begin
    head_x_next = head_x_reg;
    head_y_next = head_y_reg;
    collide     = 1'b0;
    case (pend_dir_reg)
      UP: begin
        if (head_y_reg == '0) begin
`ifdef SNAKE_WRAP_EN
          head_y_next = Y_MAX;
`else
          collide = 1'b1;
`endif
        end else begin
          head_y_next = head_y_reg - YW'(1);
        end
      end
      DOWN: begin
        if (head_y_reg == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
          head_y_next = '0;
`else
          collide = 1'b1;
`endif
        end else begin
          head_y_next = head_y_reg + YW'(1);
        end
      end
      LEFT: begin
        if (head_x_reg == '0) begin
`ifdef SNAKE_WRAP_EN
          head_x_next = X_MAX;
`else
          collide = 1'b1;
`endif
        end else begin
          head_x_next = head_x_reg - XW'(1);
        end
      end
      default: begin
        if (head_x_reg == X_MAX) begin
`ifdef SNAKE_WRAP_EN
          head_x_next = '0;
`else
          collide = 1'b1;
`endif
        end else begin
          head_x_next = head_x_reg + XW'(1);
        end
      end
    endcase
  end

  // Food candidate folded into the grid and nudged off the new head.
  always_comb begin
    eat    = (head_x_next == food_x_reg) && (head_y_next == food_y_reg);
    fx_raw = lfsr_reg[XW-1:0];
    fy_raw = lfsr_reg[XW+YW-1:XW];
    food_x_next = fx_raw;
    food_y_next = fy_raw;
    if ({1'b0, fx_raw} >= GRID_W_EXT) begin
      food_x_next = fx_raw - GRID_W_EXT[XW-1:0];
    end
    if ({1'b0, fy_raw} >= GRID_H_EXT) begin
      food_y_next = fy_raw - GRID_H_EXT[YW-1:0];
    end
    if ((food_x_next == head_x_next) && (food_y_next == head_y_next)) begin
      food_x_next = (food_x_next == X_MAX) ? '0 : food_x_next + XW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    if (restart) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  if (run) state_next = RUN;
        RUN: begin
          if (!run) begin
            state_next = PAUSE;
          end else if (tick && collide) begin
            state_next = OVER;
          end
        end
        PAUSE: if (run) state_next = RUN;
        default: state_next = OVER;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      head_x_reg   <= X_START;
      head_y_reg   <= Y_START;
      food_x_reg   <= X_FOOD0;
      food_y_reg   <= Y_START;
      cur_dir_reg  <= RIGHT;
      pend_dir_reg <= RIGHT;
      score_reg    <= '0;
      step_reg     <= 1'b0;
      lfsr_reg     <= LFSR_SEED;
    end else if (restart) begin
      head_x_reg   <= X_START;
      head_y_reg   <= Y_START;
      food_x_reg   <= X_FOOD0;
      food_y_reg   <= Y_START;
      cur_dir_reg  <= RIGHT;
      pend_dir_reg <= RIGHT;
      score_reg    <= '0;
      step_reg     <= 1'b0;
      lfsr_reg     <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);
      step_reg <= 1'b0;
      if (!is_reverse(dir_in, cur_dir_reg)) begin
        pend_dir_reg <= dir_in;
      end
      if (tick) begin
        cur_dir_reg <= pend_dir_reg;
        // A collision freezes head and score; the FSM moves to OVER instead.
        if (!collide) begin
          head_x_reg <= head_x_next;
          head_y_reg <= head_y_next;
          step_reg   <= 1'b1;
          if (eat) begin
            food_x_reg <= food_x_next;
            food_y_reg <= food_y_next;
            if (score_reg != '1) begin
              score_reg <= score_reg + SCORE_W'(1);
            end
          end
        end
      end
    end
  end

  assign head_x    = head_x_reg;
  assign head_y    = head_y_reg;
  assign food_x    = food_x_reg;
  assign food_y    = food_y_reg;
  assign score     = score_reg;
  assign step      = step_reg;
  assign state     = state_reg;
  assign game_over = (state_reg == OVER);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_DIV=4; honours SNAKE_WRAP_EN.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] direction;
  logic       run;
  logic       restart;
  logic [4:0] head_x, food_x;
  logic [4:0] head_y, food_y;
  logic [7:0] score;
  logic       step;
  logic [1:0] state;
  logic       game_over;

  int tests = 0;
  int fails = 0;

  snake_game_ctrl #(
    .GRID_W   (32),
    .GRID_H   (24),
    .XW       (5),
    .YW       (5),
    .TICK_DIV (4),
    .START_X  (16),
    .START_Y  (12),
    .SCORE_W  (8)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .direction (direction),
    .run       (run),
    .restart   (restart),
    .head_x    (head_x),
    .head_y    (head_y),
    .food_x    (food_x),
    .food_y    (food_y),
    .score     (score),
    .step      (step),
    .state     (state),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    check({tag, "_hx"}, int'(head_x), x);
    check({tag, "_hy"}, int'(head_y), y);
  endtask

  task automatic check_reset(input string tag);
    check_head(tag, 16, 12);
    check({tag, "_fx"}, int'(food_x), 20);
    check({tag, "_fy"}, int'(food_y), 12);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_step"}, int'(step), 0);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_over"}, int'(game_over), 0);
  endtask

  // Counts negedges until step is seen (bounded) and checks the latency.
  task automatic wait_step(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step !== 1'b1 && n < 20);
    check({tag, "_lat"}, n, exp_n);
  endtask

  initial begin
    clr = 1'b1; run = 1'b0; restart = 1'b0; direction = 2'b11;
    repeat (2) @(negedge clk);
    check_reset("rst");
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("idle");

    // Run right from reset; the fourth step lands on the initial food.
    run = 1'b1;
    wait_step("t1_s1", 5);
    check_head("t1_s1", 17, 12);
    check("t1_state", int'(state), 1);
    @(negedge clk);
    check("t1_pulse", int'(step), 0);
    wait_step("t1_s2", 3);
    check_head("t1_s2", 18, 12);
    wait_step("t1_s3", 4);
    check_head("t1_s3", 19, 12);
    check("t1_score0", int'(score), 0);
    wait_step("t3_eat", 4);
    check_head("t3_eat", 20, 12);
    check("t3_score1", int'(score), 1);
    check("t3_fy_range", int'(food_y < 5'd24), 1);
    check("t3_f_not_head", int'((food_x != head_x) || (food_y != head_y)), 1);

    // Reverse request ignored, then turn up.
    direction = 2'b10;
    wait_step("t2_rev", 4);
    check_head("t2_rev", 21, 12);
    direction = 2'b00;
    wait_step("t2_up", 4);
    check_head("t2_up", 21, 11);

    // run falls in the tick cycle: that tick is dropped.
    repeat (3) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("t4_drop_state", int'(state), 2);
    check("t4_drop_step", int'(step), 0);
    check_head("t4_drop", 21, 11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_pause_step", int'(step), 0);
    end
    check_head("t4_pause", 21, 11);
    run = 1'b1;
    @(negedge clk);
    check("t4_resume_state", int'(state), 1);
    wait_step("t4_resume", 4);
    check_head("t4_resume", 21, 10);

    // Pause mid-interval, then resume.
    @(negedge clk);
    run = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_mid_state", int'(state), 2);
    check_head("t4_mid", 21, 10);
    run = 1'b1;
    wait_step("t4_mid_resume", 5);
    check_head("t4_mid_resume", 21, 9);

    // Climb to row 5 then head right to the last column.
    for (int y = 8; y >= 5; y--) begin
      wait_step("t5_up", 4);
      check_head("t5_up", 21, y);
    end
    direction = 2'b11;
    for (int x = 22; x <= 31; x++) begin
      wait_step("t5_right", 4);
      check_head("t5_right", x, 5);
    end

    repeat (4) @(negedge clk);
`ifdef SNAKE_WRAP_EN
    check("t5_wrap_step", int'(step), 1);
    check_head("t5_wrap", 0, 5);
    check("t5_wrap_state", int'(state), 1);
    check("t5_wrap_over", int'(game_over), 0);
`else
    check("t5_over_state", int'(state), 3);
    check("t5_over_flag", int'(game_over), 1);
    check("t5_over_step", int'(step), 0);
    check_head("t5_over", 31, 5);
    repeat (5) @(negedge clk);
    check("t5_hold_state", int'(state), 3);
    check_head("t5_hold", 31, 5);

    // Restart out of OVER.
    restart = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check_reset("t6_over_rs");
    restart = 1'b0;
    @(negedge clk);
    check("t6_idle_state", int'(state), 0);
`endif

    // Restart mid-RUN.
    run = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_step("t6_run", 5);
    check_head("t6_run", 17, 12);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    check_reset("t6_mid_rs");
    restart = 1'b0;
    wait_step("t6_rerun", 5);
    check_head("t6_rerun", 17, 12);

    // Asynchronous clear between clock edges.
    @(negedge clk);
    #2 clr = 1'b1;
    #1 check_reset("t6_clr");
    @(negedge clk);
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
